// File: rtl/display_share_ctrl.sv
// Shares the 4-digit BCD display between a live primary value (A) and a
// request-driven secondary message (B) with timed hold, req/ack and zero blanking.
module display_share_ctrl #(
  parameter int DIV  = 100000,
  parameter int HOLD = 2000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [15:0] Val_A,
  input  logic        Req_B,
  input  logic [15:0] Val_B,
  input  logic        Blank_Zeros,
  output logic        Ack_B,
  output logic        Busy,
  output logic        Src,
  output logic [3:0]  Uni,
  output logic [3:0]  Dec,
  output logic [3:0]  Cen,
  output logic [3:0]  Mil
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HW = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD - 1);

  typedef enum logic [1:0] {
    SHOW_A   = 2'd0,
    SHOW_B   = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  state_t        state_r;
  logic [PW-1:0] presc_r;
  logic [HW-1:0] hold_r;
  logic [15:0]   val_b_r;
  logic          req_prev_r;
  logic          ack_r;
  logic          busy_r;
  logic          src_r;
  logic [15:0]   digits_r;

  logic          tick_s;
  logic          expire_s;
  logic          rise_s;
  logic [15:0]   shown_s;

  // Invalid nibbles become blank; leading zeros blank from the top down, units never.
  function automatic logic [15:0] form_digits(input logic [15:0] v, input logic bz);
    logic [3:0] n [4];
    logic       blank_mil;
    logic       blank_cen;
    logic       blank_dec;
    for (int i = 0; i < 4; i++) begin
      n[i] = (v[4*i +: 4] > 4'd9) ? 4'hF : v[4*i +: 4];
    end
    blank_mil = bz && (n[3] == 4'd0);
    blank_cen = blank_mil && (n[2] == 4'd0);
    blank_dec = blank_cen && (n[1] == 4'd0);
    return {blank_mil ? 4'hF : n[3],
            blank_cen ? 4'hF : n[2],
            blank_dec ? 4'hF : n[1],
            n[0]};
  endfunction

  assign tick_s   = (presc_r == PRESC_LAST);
  assign expire_s = tick_s && (hold_r == HOLD_LAST);
  assign rise_s   = Req_B && !req_prev_r;

  // Digit source follows the registered Src, so digits trail Src by one cycle.
  always_comb begin
    shown_s = Val_A;
    if (src_r) begin
      shown_s = val_b_r;
    end else begin
      shown_s = Val_A;
    end
  end

  // Sharing FSM with prescaler, hold counter, B latch and registered handshake outputs.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_r    <= SHOW_A;
      presc_r    <= '0;
      hold_r     <= '0;
      val_b_r    <= 16'h0000;
      req_prev_r <= 1'b0;
      ack_r      <= 1'b0;
      busy_r     <= 1'b0;
      src_r      <= 1'b0;
    end else begin
      req_prev_r <= Req_B;
      ack_r      <= 1'b0;
      case (state_r)
        SHOW_A: begin
          if (Req_B) begin
            val_b_r <= Val_B;
            ack_r   <= 1'b1;
            src_r   <= 1'b1;
            busy_r  <= 1'b1;
            presc_r <= '0;
            hold_r  <= '0;
            state_r <= SHOW_B;
          end else begin
            state_r <= SHOW_A;
          end
        end
        SHOW_B: begin
          // A fresh rising request outranks hold expiry on the same edge.
          if (rise_s) begin
            val_b_r <= Val_B;
            ack_r   <= 1'b1;
            src_r   <= 1'b1;
            busy_r  <= 1'b1;
            presc_r <= '0;
            hold_r  <= '0;
            state_r <= SHOW_B;
          end else if (expire_s) begin
            src_r   <= 1'b0;
            busy_r  <= 1'b0;
            presc_r <= '0;
            hold_r  <= '0;
            state_r <= Req_B ? WAIT_REL : SHOW_A;
          end else begin
            presc_r <= tick_s ? '0 : presc_r + 1'b1;
            hold_r  <= tick_s ? hold_r + 1'b1 : hold_r;
            state_r <= SHOW_B;
          end
        end
        WAIT_REL: begin
          if (!Req_B) begin
            state_r <= SHOW_A;
          end else begin
            state_r <= WAIT_REL;
          end
        end
        default: begin
          src_r   <= 1'b0;
          busy_r  <= 1'b0;
          presc_r <= '0;
          hold_r  <= '0;
          state_r <= SHOW_A;
        end
      endcase
    end
  end

  // Registered digit codes toward the display controller.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      digits_r <= 16'h0000;
    end else begin
      digits_r <= form_digits(shown_s, Blank_Zeros);
    end
  end

  assign Ack_B = ack_r;
  assign Busy  = busy_r;
  assign Src   = src_r;
  assign Mil   = digits_r[15:12];
  assign Cen   = digits_r[11:8];
  assign Dec   = digits_r[7:4];
  assign Uni   = digits_r[3:0];

endmodule
